// File: rtl/conv_axis_tx.sv
// conv_axis_tx: buffers the convolution core's unthrottled pixel stream and emits it as an AXI4-Stream master.
// Optional feature: define CONV_TX_LEN_CHECK_EN to add a per-frame beat counter and the sticky len_err output.
module conv_axis_tx #(
    parameter int DEPTH     = 16,
    parameter int AF_LEVEL  = 12,
    parameter int FRAME_LEN = 304964
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   frame_done,
    output logic                   busy,
`ifdef CONV_TX_LEN_CHECK_EN
    output logic                   len_err,
`endif
    input  logic                   clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [LW-1:0] count_next;
    logic [32:0]   head;
    logic [1:0]    state;
    logic          last_dropped;
    logic          rd_en;
    logic          wr_en;
    logic          drop;
    logic          frame_end;

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head[31:0] : 32'd0;
    assign m_axis_tlast  = m_axis_tvalid & head[32];
    assign level         = count;
    assign busy          = (state != S_IDLE);

    // A full FIFO still accepts a beat when the head leaves on the same edge.
    assign rd_en = m_axis_tvalid && m_axis_tready;
    assign wr_en = in_valid && ((count != DEPTH_L) || rd_en);
    assign drop  = in_valid && !wr_en;

    // A dropped tlast can never be handshaked, so that frame closes once the FIFO runs dry.
    assign frame_end = (state == S_DRAIN) &&
                       (last_dropped ? (count == '0) : (rd_en && m_axis_tlast));

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + LW'(1);
            2'b01:   count_next = count - LW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_last, in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count       <= count_next;
            almost_full <= (count_next >= AF_L);
            if (drop)         overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            last_dropped <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= frame_end;
            case (state)
                S_IDLE, S_ACTIVE: begin
                    if (in_valid && in_last) begin
                        state        <= S_DRAIN;
                        last_dropped <= drop;
                    end else if (wr_en) begin
                        state <= S_ACTIVE;
                    end
                end
                S_DRAIN: begin
                    if (frame_end) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_TX_LEN_CHECK_EN
    logic [31:0] beat_cnt;

    // Dropped beats still count: the length error describes what the core sent, not what survived.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            if (in_valid) beat_cnt <= in_last ? 32'd0 : beat_cnt + 32'd1;
            if (in_valid && in_last && ((beat_cnt + 32'd1) != 32'(FRAME_LEN)))
                len_err <= 1'b1;
            else if (clr_err)
                len_err <= 1'b0;
        end
    end
`else
    logic unused_frame_len;
    assign unused_frame_len = (FRAME_LEN == 0);
`endif

endmodule
